// File: rtl/dtree_feature_loader.sv
// rtl/dtree_feature_loader.sv - byte-stream feature loader and class capture around the decision tree
module dtree_feature_loader #(
    parameter int N_FEAT        = 18,
    parameter int FEAT_W        = 8,
    parameter int CLASS_W       = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [N_FEAT*FEAT_W-1:0]   feat_bus,
    input  logic [CLASS_W-1:0]         class_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CLASS_W-1:0]         m_class,
    output logic [7:0]                 m_seq,
    output logic                       frame_err
);

    localparam int IDX_W = $clog2(N_FEAT);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [7:0]           seq, seq_nxt;
    logic [CLASS_W-1:0]   m_class_nxt;
    logic [7:0]           m_seq_nxt;
    logic                 frame_err_nxt;
    logic                 wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            cnt       <= '0;
            seq       <= '0;
            m_class   <= '0;
            m_seq     <= '0;
            frame_err <= 1'b0;
            feat_bus  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            seq       <= seq_nxt;
            m_class   <= m_class_nxt;
            m_seq     <= m_seq_nxt;
            frame_err <= frame_err_nxt;
            // The tree sees a new value only when a byte is accepted in LOAD.
            if (wr_en) begin
                feat_bus[idx*FEAT_W +: FEAT_W] <= s_data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        seq_nxt       = seq;
        m_class_nxt   = m_class;
        m_seq_nxt     = m_seq;
        frame_err_nxt = 1'b0;
        wr_en         = 1'b0;
        s_ready       = (state == LOAD);
        m_valid       = (state == HOLD);

        case (state)
            LOAD: begin
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        // The frame closes on the last slot even if s_last is missing.
                        frame_err_nxt = !s_last;
                        idx_nxt       = '0;
                        cnt_nxt       = CNT_INIT;
                        state_nxt     = SETTLE;
                    end else if (s_last) begin
                        frame_err_nxt = 1'b1;
                        idx_nxt       = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    m_class_nxt = class_in;
                    m_seq_nxt   = seq;
                    seq_nxt     = seq + 8'd1;
                    state_nxt   = HOLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// tb/tb_dtree_feature_loader.sv - directed self-checking bench for dtree_feature_loader
module tb_dtree_feature_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic [143:0] feat_bus;
    logic [1:0]   class_in;
    logic         m_valid;
    logic         m_ready;
    logic [1:0]   m_class;
    logic [7:0]   m_seq;
    logic         frame_err;

    int           vectors = 0;
    int           miscompares = 0;
    logic [143:0] exp_bus;
    int           exp_idx;

    dtree_feature_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .feat_bus  (feat_bus),
        .class_in  (class_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_class   (m_class),
        .m_seq     (m_seq),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        exp_bus = '0;
        exp_idx = 0;
    endtask

    // Present one byte, wait for its accept edge, then check frame_err against the frame model.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int   n;
        logic acc;
        logic exp_err;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            acc = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!acc) begin
            check("accept_timeout", acc, 1'b1);
        end else begin
            exp_bus[exp_idx*8 +: 8] = d;
            if (exp_idx == 17) begin
                exp_err = !last;
                exp_idx = 0;
            end else if (last) begin
                exp_err = 1'b1;
                exp_idx = 0;
            end else begin
                exp_err = 1'b0;
                exp_idx++;
            end
            check("frame_err", frame_err, exp_err);
        end
        repeat (gap) tick();
    endtask

    task automatic wait_result(input string tag, input logic [1:0] cls, input logic [7:0] seq);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, m_valid, 1'b1);
        check({tag, "_class"}, m_class, cls);
        check({tag, "_seq"}, m_seq, seq);
        check({tag, "_bus"}, feat_bus, exp_bus);
    endtask

    initial begin
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        class_in = 2'd0;
        m_ready  = 1'b1;
        exp_bus  = '0;
        exp_idx  = 0;

        do_reset();
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_bus", feat_bus, 144'h0);
        check("rst_m_seq", m_seq, 8'h00);
        check("rst_m_class", m_class, 2'd0);
        check("rst_frame_err", frame_err, 1'b0);

        // Nominal frame with exact settle latency.
        class_in = 2'd3;
        for (int b = 0; b < 18; b++) send_byte(8'(b), b == 17, 0);
        check("nom_s_ready_settle", s_ready, 1'b0);
        check("nom_m_valid_k", m_valid, 1'b0);
        for (int c = 1; c < 4; c++) begin
            tick();
            check("nom_m_valid_early", m_valid, 1'b0);
        end
        tick();
        check("nom_m_valid", m_valid, 1'b1);
        check("nom_m_class", m_class, 2'd3);
        check("nom_m_seq", m_seq, 8'd0);
        check("nom_slot0", feat_bus[7:0], 8'h00);
        check("nom_slot17", feat_bus[143:136], 8'h11);
        check("nom_bus", feat_bus, exp_bus);
        tick();
        check("nom_m_valid_drop", m_valid, 1'b0);
        check("nom_s_ready_back", s_ready, 1'b1);

        // Back-pressure in HOLD.
        m_ready  = 1'b0;
        class_in = 2'd1;
        for (int b = 0; b < 18; b++) send_byte(8'h20 + 8'(b), b == 17, 0);
        wait_result("bp", 2'd1, 8'd1);
        for (int c = 0; c < 10; c++) begin
            class_in = ~class_in;
            s_valid  = c[0];
            s_data   = 8'hEE;
            tick();
            check("bp_m_valid", m_valid, 1'b1);
            check("bp_m_class", m_class, 2'd1);
            check("bp_m_seq", m_seq, 8'd1);
            check("bp_bus", feat_bus, exp_bus);
            check("bp_s_ready", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("bp_release_valid", m_valid, 1'b0);
        check("bp_release_ready", s_ready, 1'b1);

        // Reset mid-frame after 7 bytes.
        for (int b = 0; b < 7; b++) send_byte(8'hA0 + 8'(b), 1'b0, 0);
        do_reset();
        check("mrst_s_ready", s_ready, 1'b1);
        check("mrst_m_valid", m_valid, 1'b0);
        check("mrst_bus", feat_bus, 144'h0);
        check("mrst_m_seq", m_seq, 8'd0);

        // Short frame: s_last on the 5th byte.
        for (int b = 0; b < 5; b++) send_byte(8'h50 + 8'(b), b == 4, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("short_frame_err_drop", frame_err, 1'b0);
            check("short_no_result", m_valid, 1'b0);
        end
        class_in = 2'd2;
        for (int b = 0; b < 18; b++) send_byte(8'h60 + 8'(b), b == 17, 0);
        wait_result("after_short", 2'd2, 8'd0);

        // Missing s_last: frame still classified, next byte starts a new frame.
        class_in = 2'd1;
        for (int b = 0; b < 18; b++) send_byte(8'h80 + 8'(b), 1'b0, 0);
        wait_result("nolast", 2'd1, 8'd1);
        send_byte(8'hAB, 1'b0, 0);
        check("nolast_slot0", feat_bus[7:0], 8'hAB);
        check("nolast_slot1_kept", feat_bus[15:8], 8'h81);
        check("nolast_bus", feat_bus, exp_bus);
        class_in = 2'd0;
        for (int b = 1; b < 18; b++) send_byte(8'hC0 + 8'(b), b == 17, 0);
        wait_result("nolast_next", 2'd0, 8'd2);

        // 257 frames with gapped s_valid: sequence wraps 255 -> 0.
        do_reset();
        for (int f = 0; f < 257; f++) begin
            class_in = 2'(f);
            for (int b = 0; b < 18; b++) send_byte(8'(f + b), b == 17, (b % 3 == 2) ? 1 : 0);
            wait_result("wrap", 2'(f), 8'(f));
        end
        tick();
        check("wrap_final_drop", m_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
